// File: rtl/localization_sequencer_if.sv
// Handshake bundle between the localization sequencer and its sources, binner and result sink.
// The slave modport is the sequencer's view; master is the environment driving it.
interface localization_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SRC    = 4
);
  localparam int unsigned SrcWidth = $clog2(NUM_SRC);

  logic                              start_in;
  logic [NUM_SRC-1:0]                req_valid_in;
  logic [NUM_SRC*DATA_WIDTH-1:0]     req_direction_in;
  logic [NUM_SRC*DATA_WIDTH/2-1:0]   req_magnitude_in;
  logic [NUM_SRC-1:0]                req_ready_out;
  logic                              binner_rst_out;
  logic                              dir_valid_out;
  logic [DATA_WIDTH-1:0]             dir_out;
  logic [DATA_WIDTH/2-1:0]           mag_out;
  logic                              binner_ready_in;
  logic [4:0]                        bin_in;
  logic                              bin_valid_in;
  logic                              binner_tready_out;
  logic [4:0]                        result_bin_out;
  logic [SrcWidth-1:0]               result_src_out;
  logic                              result_valid_out;
  logic                              result_ready_in;
  logic                              busy_out;
  logic                              timeout_out;

  modport slave (
    input  start_in, req_valid_in, req_direction_in, req_magnitude_in, binner_ready_in,
    input  bin_in, bin_valid_in, result_ready_in,
    output req_ready_out, binner_rst_out, dir_valid_out, dir_out, mag_out, binner_tready_out,
    output result_bin_out, result_src_out, result_valid_out, busy_out, timeout_out
  );

  modport master (
    output start_in, req_valid_in, req_direction_in, req_magnitude_in, binner_ready_in,
    output bin_in, bin_valid_in, result_ready_in,
    input  req_ready_out, binner_rst_out, dir_valid_out, dir_out, mag_out, binner_tready_out,
    input  result_bin_out, result_src_out, result_valid_out, busy_out, timeout_out
  );
endinterface

// File: rtl/localization_sequencer.sv
// Runs one localization window on the shared direction binner: clear, round-robin feed of
// QUANTITY samples, wait for the winning bin, hand it downstream; times out a stalled binner.
module localization_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned QUANTITY       = 199,
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                     clk_in,
  input logic                     rst_n_in,
  localization_sequencer_if.slave bus
);
  localparam int unsigned MagWidth  = DATA_WIDTH / 2;
  localparam int unsigned SrcWidth  = $clog2(NUM_SRC);
  localparam int unsigned CntWidth  = $clog2(QUANTITY + 1);
  localparam int unsigned WaitWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SrcWidth:0]    NumSrcW = (SrcWidth + 1)'(NUM_SRC);
  localparam logic [SrcWidth-1:0]  LastSrc = SrcWidth'(NUM_SRC - 1);
  localparam logic [CntWidth-1:0]  Quota   = CntWidth'(QUANTITY);
  localparam logic [WaitWidth-1:0] WaitEnd = WaitWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [WaitWidth-1:0] WaitMax = {WaitWidth{1'b1}};

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StHold, StFlush} state_e;

  state_e                state_q;
  logic [SrcWidth-1:0]   ptr_q;
  logic [CntWidth-1:0]   admitted_q;
  logic [CntWidth-1:0]   src_cnt_q [NUM_SRC];
  logic [WaitWidth-1:0]  wait_q;
  logic                  clr_cnt_q;
  logic                  binner_rst_q;
  logic                  dir_valid_q;
  logic [DATA_WIDTH-1:0] dir_q;
  logic [MagWidth-1:0]   mag_q;
  logic                  tready_q;
  logic [4:0]            result_bin_q;
  logic [SrcWidth-1:0]   result_src_q;
  logic                  result_valid_q;
  logic                  timeout_q;

  logic [DATA_WIDTH-1:0] req_dir [NUM_SRC];
  logic [MagWidth-1:0]   req_mag [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_unpack
    assign req_dir[g] = bus.req_direction_in[g*DATA_WIDTH +: DATA_WIDTH];
    assign req_mag[g] = bus.req_magnitude_in[g*MagWidth +: MagWidth];
  end

  // Round-robin search: first valid source at or after the pointer.
  logic [SrcWidth:0]   rr_sum;
  logic [SrcWidth-1:0] rr_idx;
  logic                grant_found;
  logic [SrcWidth-1:0] grant_idx;

  always_comb begin
    rr_sum      = '0;
    rr_idx      = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      rr_sum = {1'b0, ptr_q} + (SrcWidth + 1)'(k);
      if (rr_sum >= NumSrcW) rr_sum = rr_sum - NumSrcW;
      rr_idx = rr_sum[SrcWidth-1:0];
      if (!grant_found && bus.req_valid_in[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  // The output stage can take a new beat if empty or if its current beat leaves this cycle.
  logic stage_free;
  logic grant_en;
  assign stage_free = !dir_valid_q || bus.binner_ready_in;
  assign grant_en   = (state_q == StFeed) && (admitted_q < Quota) && stage_free && grant_found;

  always_comb begin
    bus.req_ready_out = '0;
    if (grant_en) bus.req_ready_out[grant_idx] = 1'b1;
  end

  // Busiest source of the window; strict compare keeps the lowest index on a tie.
  logic [SrcWidth-1:0] best_idx;
  logic [CntWidth-1:0] best_cnt;

  always_comb begin
    best_idx = '0;
    best_cnt = src_cnt_q[0];
    for (int unsigned k = 1; k < NUM_SRC; k++) begin
      if (src_cnt_q[k] > best_cnt) begin
        best_cnt = src_cnt_q[k];
        best_idx = SrcWidth'(k);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      admitted_q     <= '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) src_cnt_q[k] <= '0;
      wait_q         <= '0;
      clr_cnt_q      <= 1'b0;
      binner_rst_q   <= 1'b0;
      dir_valid_q    <= 1'b0;
      dir_q          <= '0;
      mag_q          <= '0;
      tready_q       <= 1'b0;
      result_bin_q   <= '0;
      result_src_q   <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start_in) begin
            state_q      <= StClear;
            binner_rst_q <= 1'b1;
            clr_cnt_q    <= 1'b0;
          end
        end
        StClear: begin
          admitted_q <= '0;
          for (int unsigned k = 0; k < NUM_SRC; k++) src_cnt_q[k] <= '0;
          clr_cnt_q <= 1'b1;
          if (clr_cnt_q) begin
            binner_rst_q <= 1'b0;
            state_q      <= StFeed;
          end
        end
        StFeed: begin
          if (grant_en) begin
            dir_valid_q          <= 1'b1;
            dir_q                <= req_dir[grant_idx];
            mag_q                <= req_mag[grant_idx];
            admitted_q           <= admitted_q + CntWidth'(1);
            src_cnt_q[grant_idx] <= src_cnt_q[grant_idx] + CntWidth'(1);
            ptr_q                <= (grant_idx == LastSrc) ? '0 : grant_idx + SrcWidth'(1);
          end else if (dir_valid_q && bus.binner_ready_in) begin
            dir_valid_q <= 1'b0;
          end
          if ((admitted_q == Quota) && stage_free) begin
            state_q  <= StDrain;
            tready_q <= 1'b1;
            wait_q   <= '0;
          end
        end
        StDrain: begin
          if (bus.bin_valid_in) begin
            result_bin_q   <= bus.bin_in;
            result_src_q   <= best_idx;
            result_valid_q <= 1'b1;
            tready_q       <= 1'b0;
            state_q        <= StHold;
          end else if (wait_q >= WaitEnd) begin
            timeout_q    <= 1'b1;
            binner_rst_q <= 1'b1;
            clr_cnt_q    <= 1'b0;
            tready_q     <= 1'b0;
            state_q      <= StFlush;
          end else if (wait_q != WaitMax) begin
            wait_q <= wait_q + WaitWidth'(1);
          end
        end
        StHold: begin
          if (bus.result_ready_in) begin
            result_valid_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        StFlush: begin
          clr_cnt_q <= 1'b1;
          if (clr_cnt_q) begin
            binner_rst_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.binner_rst_out    = binner_rst_q;
  assign bus.dir_valid_out     = dir_valid_q;
  assign bus.dir_out           = dir_q;
  assign bus.mag_out           = mag_q;
  assign bus.binner_tready_out = tready_q;
  assign bus.result_bin_out    = result_bin_q;
  assign bus.result_src_out    = result_src_q;
  assign bus.result_valid_out  = result_valid_q;
  assign bus.busy_out          = (state_q != StIdle);
  assign bus.timeout_out       = timeout_q;
endmodule

// File: tb/tb_localization_sequencer.sv
// Directed/randomised bench for localization_sequencer with a queue-free transaction model
// (round-robin pick, beat counts, argmax) computed from the sequencing rules.
module tb_localization_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned Q  = 8;
  localparam int unsigned TO = 16;
  localparam int unsigned MW = DW / 2;
  localparam int unsigned SW = $clog2(NS);

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  localization_sequencer_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

  localization_sequencer #(
    .DATA_WIDTH    (DW),
    .QUANTITY      (Q),
    .NUM_SRC       (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int            m_ptr = 0;
  int            m_adm;
  int            m_acc;
  int            m_cnt [NS];
  bit            m_full;
  logic [DW-1:0] m_dir;
  logic [MW-1:0] m_mag;
  int            grants[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int pick(input logic [NS-1:0] v);
    for (int k = 0; k < NS; k++) begin
      if (v[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
    end
    return -1;
  endfunction

  function automatic logic [SW-1:0] exp_src();
    int best = 0;
    for (int k = 1; k < NS; k++) if (m_cnt[k] > m_cnt[best]) best = k;
    return SW'(best);
  endfunction

  task automatic start_window();
    m_adm = 0; m_acc = 0; m_full = 0;
    for (int k = 0; k < NS; k++) m_cnt[k] = 0;
    grants.delete();
    bus.start_in = 1'b1;
    tick();
    bus.start_in     = 1'b0;
    bus.req_valid_in = NS'($urandom);
    #1;
    chk("clear_rst0", bus.binner_rst_out, 1);
    chk("clear_busy", bus.busy_out, 1);
    chk("clear_no_grant", bus.req_ready_out, 0);
    tick();
    chk("clear_rst1", bus.binner_rst_out, 1);
    tick();
    chk("clear_done", bus.binner_rst_out, 0);
  endtask

  // vmode: 0 all valid, 1 only source 2, 2 random; rmode: 0 ready, 1 1,0,0,1 pattern, 2 random
  task automatic feed(input int vmode, input int rmode, input int stop_at, output bit ok);
    int cyc = 0;
    int g;
    bit rdy;
    logic [NS-1:0] rexp;
    ok = 0;
    while (cyc < 400) begin
      case (vmode)
        0:       bus.req_valid_in = '1;
        1:       bus.req_valid_in = NS'(4);
        default: bus.req_valid_in = NS'($urandom_range(0, (1 << NS) - 1));
      endcase
      for (int i = 0; i < NS; i++) begin
        bus.req_direction_in[i*DW +: DW] = $urandom;
        bus.req_magnitude_in[i*MW +: MW] = MW'($urandom);
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.binner_ready_in = rdy;
      #1;
      g    = (m_adm < Q && (!m_full || rdy)) ? pick(bus.req_valid_in) : -1;
      rexp = (g >= 0) ? NS'(1 << g) : '0;
      chk("req_ready", bus.req_ready_out, rexp);
      chk("dir_valid", bus.dir_valid_out, m_full);
      if (m_full) begin
        chk("dir_out", bus.dir_out, m_dir);
        chk("mag_out", bus.mag_out, m_mag);
      end
      @(posedge clk_in);
      if (m_full && rdy) m_acc++;
      if (g >= 0) begin
        m_dir  = bus.req_direction_in[g*DW +: DW];
        m_mag  = bus.req_magnitude_in[g*MW +: MW];
        m_full = 1;
        m_adm++;
        m_cnt[g]++;
        m_ptr = (g + 1) % NS;
        grants.push_back(g);
      end else if (m_full && rdy) begin
        m_full = 0;
      end
      #1;
      cyc++;
      if (stop_at >= 0 && m_adm == stop_at) begin
        ok = 1;
        return;
      end
      if (m_adm == Q && !m_full) begin
        ok = 1;
        bus.req_valid_in = '0;
        return;
      end
    end
  endtask

  task automatic hold_check(input logic [4:0] b, input logic [SW-1:0] s);
    for (int i = 0; i < 10; i++) begin
      bus.result_ready_in = 1'b0;
      bus.start_in        = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", bus.result_valid_out, 1);
      chk("hold_bin", bus.result_bin_out, b);
      chk("hold_src", bus.result_src_out, s);
      chk("hold_no_clear", bus.binner_rst_out, 0);
    end
    bus.start_in        = 1'b1;
    bus.result_ready_in = 1'b1;
    tick();
    bus.start_in        = 1'b0;
    bus.result_ready_in = 1'b0;
    chk("accept_valid", bus.result_valid_out, 0);
    chk("accept_busy", bus.busy_out, 0);
    tick();
    chk("accept_start_ignored", bus.binner_rst_out, 0);
    chk("idle_busy", bus.busy_out, 0);
  endtask

  task automatic drain_result(input logic [4:0] b, input int delay);
    logic [SW-1:0] s;
    s = exp_src();
    chk("drain_tready", bus.binner_tready_out, 1);
    chk("drain_dir_valid", bus.dir_valid_out, 0);
    bus.bin_valid_in = 1'b0;
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("drain_wait_tready", bus.binner_tready_out, 1);
      chk("drain_wait_valid", bus.result_valid_out, 0);
    end
    bus.bin_valid_in = 1'b1;
    bus.bin_in       = b;
    tick();
    bus.bin_valid_in = 1'b0;
    bus.bin_in       = 5'($urandom);
    chk("result_valid", bus.result_valid_out, 1);
    chk("result_bin", bus.result_bin_out, b);
    chk("result_src", bus.result_src_out, s);
    chk("result_tready_low", bus.binner_tready_out, 0);
    hold_check(b, s);
  endtask

  task automatic run_window(input int vmode, input int rmode, input logic [4:0] b, input int dly);
    bit ok;
    start_window();
    feed(vmode, rmode, -1, ok);
    chk("feed_done", ok, 1);
    chk("beats_taken", m_acc, Q);
    drain_result(b, dly);
  endtask

  initial begin
    bit ok;
    bus.start_in         = 1'b0;
    bus.req_valid_in     = '0;
    bus.req_direction_in = '0;
    bus.req_magnitude_in = '0;
    bus.binner_ready_in  = 1'b0;
    bus.bin_in           = '0;
    bus.bin_valid_in     = 1'b0;
    bus.result_ready_in  = 1'b0;
    #2;
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_dir_valid", bus.dir_valid_out, 0);
    chk("rst_binner_rst", bus.binner_rst_out, 0);
    chk("rst_result_valid", bus.result_valid_out, 0);
    chk("rst_timeout", bus.timeout_out, 0);
    repeat (2) tick();
    rst_n_in = 1'b1;
    tick();

    // Ready binner, all sources: strict 0,1,2,3 rotation, tie resolves to source 0.
    start_window();
    feed(0, 0, -1, ok);
    chk("feed_done", ok, 1);
    chk("beats_taken", m_acc, Q);
    for (int k = 0; k < grants.size(); k++) chk("rr_order", grants[k], k % NS);
    drain_result(5'd5, 2);

    run_window(0, 1, 5'($urandom), 1);   // backpressured binner
    run_window(1, 0, 5'd17, 0);          // sparse source 2
    chk("sparse_src", bus.result_src_out, 2);

    // Stalled binner times out.
    start_window();
    feed(2, 2, -1, ok);
    chk("feed_done", ok, 1);
    chk("drain_entry_tready", bus.binner_tready_out, 1);
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk("to_result_valid", bus.result_valid_out, 0);
      if (k < TO) chk("to_quiet", bus.timeout_out, 0);
      if (k == TO) begin
        chk("to_pulse", bus.timeout_out, 1);
        chk("to_clear0", bus.binner_rst_out, 1);
      end
      if (k == TO + 1) begin
        chk("to_pulse_end", bus.timeout_out, 0);
        chk("to_clear1", bus.binner_rst_out, 1);
      end
      if (k == TO + 2) begin
        chk("to_clear_done", bus.binner_rst_out, 0);
        chk("to_idle", bus.busy_out, 0);
      end
    end

    // Asynchronous reset in the middle of FEED.
    start_window();
    feed(0, 0, 3, ok);
    chk("feed_to_3", ok, 1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_busy", bus.busy_out, 0);
    chk("arst_dir_valid", bus.dir_valid_out, 0);
    chk("arst_dir", bus.dir_out, 0);
    chk("arst_mag", bus.mag_out, 0);
    chk("arst_req_ready", bus.req_ready_out, 0);
    chk("arst_tready", bus.binner_tready_out, 0);
    bus.req_valid_in = '0;
    repeat (2) tick();
    rst_n_in = 1'b1;
    m_ptr    = 0;
    tick();
    run_window(0, 0, 5'd9, 3);

    for (int w = 0; w < 3; w++) run_window(2, 2, 5'($urandom), int'($urandom_range(0, 8)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
